// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: default sizing, handler base
// address, FSM state encoding and an index-width helper.
package irq_ctrl_pkg;

    localparam int N_IRQ = 8;
    localparam int VEC_W = 10;
    localparam logic [VEC_W-1:0] VEC_BASE = 10'h3F0;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SERV = 2'd2
    } irq_state_t;

    // Width of an index into an n-wide vector; never zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side handshake of the interrupt controller: request/vector out,
// ack/return in, plus the in-service vector.
interface irq_ctrl_if
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ_W = irq_ctrl_pkg::N_IRQ,
    parameter int VEC_W_W = irq_ctrl_pkg::VEC_W
);
    logic               irq_req;
    logic [VEC_W_W-1:0] irq_vec;
    logic               irq_ack;
    logic               irq_ret;
    logic [N_IRQ_W-1:0] in_srv;

    modport master (output irq_req, irq_vec, in_srv, input irq_ack, irq_ret);
    modport slave  (input irq_req, irq_vec, in_srv, output irq_ack, irq_ret);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Priority encoder: index of the highest set request bit plus a valid flag.
module irq_ctrl_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N     = irq_ctrl_pkg::N_IRQ,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx   = '0;
        valid = |req;
        // Ascending scan: the last hit, i.e. the MSB, wins.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, software mask, priority selection and
// request/in-service tracking. Define IRQ_NEST_EN to allow nested preemption.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               N_IRQ    = irq_ctrl_pkg::N_IRQ,
    parameter int               VEC_W    = irq_ctrl_pkg::VEC_W,
    parameter logic [VEC_W-1:0] VEC_BASE = irq_ctrl_pkg::VEC_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_d,
    output logic [N_IRQ-1:0] mask_q,
    output logic             ovr,
    irq_ctrl_if.master       bus
);
    localparam int IDX_W = idx_width(N_IRQ);

    irq_state_t       state_reg, state_next;
    logic [N_IRQ-1:0] pend_reg, pend_next;
    logic [N_IRQ-1:0] mask_reg;
    logic [N_IRQ-1:0] in_srv_reg, in_srv_next;
    logic [IDX_W-1:0] sel_reg, sel_next;
    logic [VEC_W-1:0] vec_reg, vec_next;
    logic             ovr_reg, ovr_next;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] sel_onehot;
    logic [N_IRQ-1:0] ovr_hit;
    logic [N_IRQ-1:0] cand_req;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_valid;

    assign cand_req = pend_reg & mask_reg;

    irq_ctrl_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_cand_enc (
        .req   (cand_req),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    // A new pulse always wins over the ack-clear of the same bit.
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_bit
            assign sel_onehot[gi] = (sel_reg == IDX_W'(gi));
            assign pend_next[gi]  = (pend_reg[gi] & ~clr[gi]) | irq_in[gi];
            assign ovr_hit[gi]    = irq_in[gi] & pend_reg[gi] & ~clr[gi];
        end
    endgenerate

    assign ovr_next = (|ovr_hit) ? 1'b1 : (mask_we ? 1'b0 : ovr_reg);

`ifdef IRQ_NEST_EN
    logic [IDX_W-1:0] srv_idx;
    logic             srv_valid;
    logic [N_IRQ-1:0] srv_top;

    irq_ctrl_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_srv_enc (
        .req   (in_srv_reg),
        .idx   (srv_idx),
        .valid (srv_valid)
    );

    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_srv_top
            assign srv_top[gi] = srv_valid && (srv_idx == IDX_W'(gi));
        end
    endgenerate
`endif

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        vec_next    = vec_reg;
        in_srv_next = in_srv_reg;
        clr         = '0;
        case (state_reg)
            IRQ_IDLE: begin
                if (cand_valid) begin
                    state_next = IRQ_REQ;
                    sel_next   = cand_idx;
                    vec_next   = VEC_BASE + VEC_W'(cand_idx);
                end
            end
            IRQ_REQ: begin
                if (bus.irq_ack) begin
                    state_next  = IRQ_SERV;
                    clr         = sel_onehot;
                    in_srv_next = in_srv_reg | sel_onehot;
                end else if (mask_we && !(|(mask_d & sel_onehot))) begin
                    // Withdrawn request falls back to whatever was running before.
                    state_next = (|in_srv_reg) ? IRQ_SERV : IRQ_IDLE;
                end
            end
            IRQ_SERV: begin
`ifdef IRQ_NEST_EN
                if (bus.irq_ret) begin
                    in_srv_next = in_srv_reg & ~srv_top;
                    state_next  = (|(in_srv_reg & ~srv_top)) ? IRQ_SERV : IRQ_IDLE;
                end else if (cand_valid && (!srv_valid || (cand_idx > srv_idx))) begin
                    state_next = IRQ_REQ;
                    sel_next   = cand_idx;
                    vec_next   = VEC_BASE + VEC_W'(cand_idx);
                end
`else
                if (bus.irq_ret) begin
                    in_srv_next = '0;
                    state_next  = IRQ_IDLE;
                end
`endif
            end
            default: begin
                state_next = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IRQ_IDLE;
            pend_reg   <= '0;
            mask_reg   <= '0;
            in_srv_reg <= '0;
            sel_reg    <= '0;
            vec_reg    <= '0;
            ovr_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            mask_reg   <= mask_we ? mask_d : mask_reg;
            in_srv_reg <= in_srv_next;
            sel_reg    <= sel_next;
            vec_reg    <= vec_next;
            ovr_reg    <= ovr_next;
        end
    end

    assign bus.irq_req = (state_reg == IRQ_REQ);
    assign bus.irq_vec = vec_reg;
    assign bus.in_srv  = in_srv_reg;
    assign mask_q      = mask_reg;
    assign ovr         = ovr_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: masking, priority, overrun, withdraw, nesting
// (IRQ_NEST_EN or not) and asynchronous reset.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_d;
    logic [7:0] mask_q;
    logic       ovr;

    int n_assert = 0;
    int n_fail   = 0;

    irq_ctrl_if #(.N_IRQ_W(8), .VEC_W_W(10)) bus ();

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .mask_q  (mask_q),
        .ovr     (ovr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mask(input logic [7:0] d);
        mask_we = 1'b1;
        mask_d  = d;
        tick();
        mask_we = 1'b0;
        $display("mask write %02h", d);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
        $display("irq pulse %02h", v);
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        $display("irq ack");
    endtask

    task automatic ret();
        bus.irq_ret = 1'b1;
        tick();
        bus.irq_ret = 1'b0;
        $display("irq ret");
    endtask

    initial begin
        reset       = 1'b1;
        irq_in      = '0;
        mask_we     = 1'b0;
        mask_d      = '0;
        bus.irq_ack = 1'b0;
        bus.irq_ret = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(bus.irq_req), 32'h0);
        chk("rst_vec", 32'(bus.irq_vec), 32'h0);
        chk("rst_srv", 32'(bus.in_srv), 32'h0);
        chk("rst_mask", 32'(mask_q), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        reset = 1'b0;
        tick();

        // 1: single source, 2-cycle latency
        set_mask(8'h80);
        chk("t1_mask", 32'(mask_q), 32'h80);
        pulse(8'h80);
        chk("t1_req_early", 32'(bus.irq_req), 32'h0);
        tick();
        chk("t1_req", 32'(bus.irq_req), 32'h1);
        chk("t1_vec", 32'(bus.irq_vec), 32'h3F7);
        ack();
        chk("t1_req_ack", 32'(bus.irq_req), 32'h0);
        chk("t1_srv", 32'(bus.in_srv), 32'h80);
        ret();
        chk("t1_srv_ret", 32'(bus.in_srv), 32'h0);
        tick();
        chk("t1_idle", 32'(bus.irq_req), 32'h0);

        // 2: two sources at once, higher index first, back-to-back
        set_mask(8'hFF);
        pulse(8'h05);
        tick();
        chk("t2_req_a", 32'(bus.irq_req), 32'h1);
        chk("t2_vec_a", 32'(bus.irq_vec), 32'h3F2);
        ack();
        chk("t2_srv_a", 32'(bus.in_srv), 32'h04);
        ret();
        chk("t2_req_gap", 32'(bus.irq_req), 32'h0);
        tick();
        chk("t2_req_b", 32'(bus.irq_req), 32'h1);
        chk("t2_vec_b", 32'(bus.irq_vec), 32'h3F0);
        ack();
        chk("t2_srv_b", 32'(bus.in_srv), 32'h01);
        ret();
        tick();
        chk("t2_empty", 32'(bus.irq_req), 32'h0);

        // 3: masked source latches, request once mask opens
        set_mask(8'h00);
        pulse(8'h08);
        tick();
        tick();
        chk("t3_masked", 32'(bus.irq_req), 32'h0);
        set_mask(8'h08);
        chk("t3_mask_edge", 32'(bus.irq_req), 32'h0);
        tick();
        chk("t3_req", 32'(bus.irq_req), 32'h1);
        chk("t3_vec", 32'(bus.irq_vec), 32'h3F3);
        ack();
        ret();
        chk("t3_srv_ret", 32'(bus.in_srv), 32'h0);

        // 4: overrun, pulse coincident with ack, mask write clears ovr
        set_mask(8'h02);
        chk("t4_ovr0", 32'(ovr), 32'h0);
        pulse(8'h02);
        tick();
        pulse(8'h02);
        chk("t4_ovr1", 32'(ovr), 32'h1);
        chk("t4_vec", 32'(bus.irq_vec), 32'h3F1);
        irq_in = 8'h02;
        ack();
        irq_in = '0;
        chk("t4_srv", 32'(bus.in_srv), 32'h02);
        chk("t4_ovr_ack", 32'(ovr), 32'h1);
        ret();
        tick();
        chk("t4_repend", 32'(bus.irq_req), 32'h1);
        set_mask(8'h02);
        chk("t4_ovr_clr", 32'(ovr), 32'h0);
        chk("t4_req_kept", 32'(bus.irq_req), 32'h1);
        ack();
        ret();
        tick();
        chk("t4_idle", 32'(bus.irq_req), 32'h0);

        // mask withdraw in REQ, then ack beats a disabling mask write
        set_mask(8'h04);
        pulse(8'h04);
        tick();
        chk("wd_req", 32'(bus.irq_req), 32'h1);
        set_mask(8'h00);
        chk("wd_withdrawn", 32'(bus.irq_req), 32'h0);
        set_mask(8'h04);
        tick();
        chk("wd_req2", 32'(bus.irq_req), 32'h1);
        mask_we     = 1'b1;
        mask_d      = 8'h00;
        bus.irq_ack = 1'b1;
        tick();
        mask_we     = 1'b0;
        bus.irq_ack = 1'b0;
        $display("mask write 00 with ack");
        chk("wd_ack_wins", 32'(bus.in_srv), 32'h04);
        chk("wd_ack_req", 32'(bus.irq_req), 32'h0);

        // 5: higher source during service of bit 2
        set_mask(8'h84);
        pulse(8'h80);
        tick();
`ifdef IRQ_NEST_EN
        chk("t5_preempt", 32'(bus.irq_req), 32'h1);
        chk("t5_vec", 32'(bus.irq_vec), 32'h3F7);
        ack();
        chk("t5_srv2", 32'(bus.in_srv), 32'h84);
        ret();
        chk("t5_srv_pop", 32'(bus.in_srv), 32'h04);
        chk("t5_req_pop", 32'(bus.irq_req), 32'h0);
        ret();
        chk("t5_srv_empty", 32'(bus.in_srv), 32'h0);
        tick();
        chk("t5_idle", 32'(bus.irq_req), 32'h0);
`else
        chk("t5_no_preempt", 32'(bus.irq_req), 32'h0);
        chk("t5_srv_kept", 32'(bus.in_srv), 32'h04);
        ret();
        chk("t5_srv_ret", 32'(bus.in_srv), 32'h0);
        tick();
        chk("t5_req", 32'(bus.irq_req), 32'h1);
        chk("t5_vec", 32'(bus.irq_vec), 32'h3F7);
        ack();
        chk("t5_srv7", 32'(bus.in_srv), 32'h80);
        ret();
        chk("t5_srv_end", 32'(bus.in_srv), 32'h0);
`endif

        // 6: asynchronous reset while in REQ
        pulse(8'h80);
        pulse(8'h80);
        chk("t6_req", 32'(bus.irq_req), 32'h1);
        chk("t6_ovr", 32'(ovr), 32'h1);
        #2 reset = 1'b1;
        #1;
        $display("async reset");
        chk("t6_rst_req", 32'(bus.irq_req), 32'h0);
        chk("t6_rst_vec", 32'(bus.irq_vec), 32'h0);
        chk("t6_rst_srv", 32'(bus.in_srv), 32'h0);
        chk("t6_rst_mask", 32'(mask_q), 32'h0);
        chk("t6_rst_ovr", 32'(ovr), 32'h0);
        bus.irq_ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        bus.irq_ack = 1'b0;
        chk("t6_ack_ign_req", 32'(bus.irq_req), 32'h0);
        chk("t6_ack_ign_srv", 32'(bus.in_srv), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
